sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares one SRAM slave port between two masters: m0 (instruction fetch, read-only) and m1 (load/store, read and write).
- Sits between the IF/MEM stages and the SRAM/bus bridge.
- Sequences single-outstanding, variable-latency reads with round-robin fairness.
- Passes m1 single-cycle writes through when no read is in flight, and supports read cancel.

Parameters:
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address width
- NUM_OF_BYTES, DATA_WIDTH/8, write-mask width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- m0_rd_en  in  1  m0 read request, held until m0_rd_valid or m0_cancel_rd
- m0_rd_addr  in  ADDR_WIDTH  m0 read address, stable while m0_rd_en
- m0_cancel_rd  in  1  m0 abandons its read
- m0_rd_valid  out  1  m0 read data valid, one cycle
- m0_rd_data  out  DATA_WIDTH  read data (shared with s_rd_data)
- m1_rd_en  in  1  m1 read request, same rules as m0
- m1_rd_addr  in  ADDR_WIDTH  m1 read address
- m1_cancel_rd  in  1  m1 abandons its read
- m1_rd_valid  out  1  m1 read data valid
- m1_rd_data  out  DATA_WIDTH  read data
- m1_wr_en  in  1  m1 write request
- m1_wr_addr  in  ADDR_WIDTH  write address
- m1_wr_data  in  DATA_WIDTH  write data
- m1_wr_mask  in  NUM_OF_BYTES  byte enables
- m1_wr_ready  out  1  write accepted this cycle when m1_wr_en && m1_wr_ready
- s_rd_en  out  1  downstream read request, registered
- s_rd_addr  out  ADDR_WIDTH  downstream read address, registered
- s_cancel_rd  out  1  downstream cancel, one-cycle pulse, registered
- s_rd_valid  in  1  downstream read data valid
- s_rd_data  in  DATA_WIDTH  downstream read data
- s_wr_en  out  1  downstream write, combinational pass-through
- s_wr_addr  out  ADDR_WIDTH  downstream write address
- s_wr_data  out  DATA_WIDTH  downstream write data
- s_wr_mask  out  NUM_OF_BYTES  downstream write mask

Behaviour:
- **Reset (async, rst=1):**
  - state=IDLE, owner=0, last_grant=1 (so m0 wins the first tie).
  - s_rd_en=0, s_rd_addr=0, s_cancel_rd=0.
  - m0_rd_valid=0, m1_rd_valid=0.
  - s_wr_en=0 whenever rst=1.
  - Reset mid-read drops the transaction; no cancel is issued.
- **States:**
  - IDLE: no read outstanding.
  - BUSY: read outstanding for owner.
- **Write path:**
  - m1_wr_ready = (state==IDLE).
  - s_wr_en = m1_wr_en & m1_wr_ready; s_wr_addr/s_wr_data/s_wr_mask mirror m1 inputs combinationally.
  - Zero-latency pass-through.
- **IDLE, per cycle:**
  - A master is eligible if rd_en=1 and cancel_rd=0.
  - If m1_wr_en=1, the write is issued and no read is granted this cycle; the write has priority.
  - Otherwise, one eligible master: grant it.
  - Otherwise, both eligible: grant the master != last_grant.
  - On grant: next cycle state=BUSY, owner=granted, last_grant=granted, s_rd_en=1, s_rd_addr=granted master's address.
- **BUSY:**
  - s_rd_en stays 1 and s_rd_addr stays stable.
  - m1_wr_ready=0.
- **Read completion:**
  - If s_rd_valid=1 and owner's cancel_rd=0: owner's rd_valid=1 in that same cycle (combinational); the other master's rd_valid stays 0.
  - Next cycle: state=IDLE, s_rd_en=0.
  - Minimum spacing between two grants is 1 IDLE cycle.
- **Read cancel:**
  - If owner's cancel_rd=1 in BUSY, the cancel wins even if s_rd_valid=1 in the same cycle. Data is dropped and rd_valid stays 0.
  - Next cycle: s_cancel_rd=1 for exactly one cycle, s_rd_en=0, state=IDLE.
  - A new grant is allowed in that cycle.
- **Ignored inputs:**
  - cancel_rd from a non-owner, or in IDLE, is not forwarded.
  - s_rd_valid in IDLE is ignored; no rd_valid is asserted.
- **Data path:** m0_rd_data = m1_rd_data = s_rd_data, qualified only by the rd_valid outputs.
- **Protocol violation:** a master dropping rd_en while owner without cancel is illegal; the bench asserts this never happens.

Test Plan:
- **Single read.** m0_rd_en=1, addr=0x1C000000 at cycle 0; slave returns 0xDEADBEEF 3 cycles after s_rd_en.
  - Required: s_rd_en=1 from cycle 1, s_rd_addr=0x1C000000.
  - Required: m0_rd_valid=1 with data 0xDEADBEEF in the s_rd_valid cycle; s_rd_en=0 the next cycle.
- **Round-robin.** m0 and m1 both hold rd_en from reset, addresses 0x100 and 0x200.
  - Required grant order: 0x100, 0x200, 0x100.
  - Each rd_valid goes only to the matching master.
- **Write priority.** m1_wr_en=1 (0x80, 0x12345678, mask 0xF) and m0_rd_en=1 in IDLE, same cycle.
  - Required: s_wr_en=1 that cycle, no grant.
  - Required: m0 granted the next cycle.
- **Write stall.** m1_wr_en=1 while BUSY.
  - Required: m1_wr_ready=0 and s_wr_en=0 until the cycle after s_rd_valid.
- **Cancel race.** Owner m1 asserts m1_cancel_rd in the same cycle as s_rd_valid.
  - Required: m1_rd_valid=0, s_cancel_rd=1 for one cycle next cycle, state IDLE.
  - Required: a pending m0 request is granted in that cycle.
- **Async reset mid-read.** Assert rst while BUSY, between clock edges.
  - Required: s_rd_en=0 and s_cancel_rd=0 immediately, state IDLE.
  - Required: after release, m0 wins a tie.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Bundles every handshake/bus signal around the SRAM arbiter.
//   master modport : the requesters and the SRAM bridge, i.e. everything outside
//                    the arbiter (drives m0/m1 requests and s_rd_valid/s_rd_data).
//   slave modport  : the arbiter itself.
// Ports:
//   m0_*  read-only channel from instruction fetch
//   m1_*  read/write channel from load/store
//   s_*   single downstream SRAM port
interface sram_arbiter_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int NUM_OF_BYTES = DATA_WIDTH / 8
);
  logic                    m0_rd_en;
  logic [ADDR_WIDTH-1:0]   m0_rd_addr;
  logic                    m0_cancel_rd;
  logic                    m0_rd_valid;
  logic [DATA_WIDTH-1:0]   m0_rd_data;

  logic                    m1_rd_en;
  logic [ADDR_WIDTH-1:0]   m1_rd_addr;
  logic                    m1_cancel_rd;
  logic                    m1_rd_valid;
  logic [DATA_WIDTH-1:0]   m1_rd_data;
  logic                    m1_wr_en;
  logic [ADDR_WIDTH-1:0]   m1_wr_addr;
  logic [DATA_WIDTH-1:0]   m1_wr_data;
  logic [NUM_OF_BYTES-1:0] m1_wr_mask;
  logic                    m1_wr_ready;

  logic                    s_rd_en;
  logic [ADDR_WIDTH-1:0]   s_rd_addr;
  logic                    s_cancel_rd;
  logic                    s_rd_valid;
  logic [DATA_WIDTH-1:0]   s_rd_data;
  logic                    s_wr_en;
  logic [ADDR_WIDTH-1:0]   s_wr_addr;
  logic [DATA_WIDTH-1:0]   s_wr_data;
  logic [NUM_OF_BYTES-1:0] s_wr_mask;

  modport master (
    output m0_rd_en, m0_rd_addr, m0_cancel_rd,
    input  m0_rd_valid, m0_rd_data,
    output m1_rd_en, m1_rd_addr, m1_cancel_rd,
    input  m1_rd_valid, m1_rd_data,
    output m1_wr_en, m1_wr_addr, m1_wr_data, m1_wr_mask,
    input  m1_wr_ready,
    input  s_rd_en, s_rd_addr, s_cancel_rd,
    output s_rd_valid, s_rd_data,
    input  s_wr_en, s_wr_addr, s_wr_data, s_wr_mask
  );

  modport slave (
    input  m0_rd_en, m0_rd_addr, m0_cancel_rd,
    output m0_rd_valid, m0_rd_data,
    input  m1_rd_en, m1_rd_addr, m1_cancel_rd,
    output m1_rd_valid, m1_rd_data,
    input  m1_wr_en, m1_wr_addr, m1_wr_data, m1_wr_mask,
    output m1_wr_ready,
    output s_rd_en, s_rd_addr, s_cancel_rd,
    input  s_rd_valid, s_rd_data,
    output s_wr_en, s_wr_addr, s_wr_data, s_wr_mask
  );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one SRAM port between m0 (instruction fetch, read-only) and m1
// (load/store). One read outstanding at a time, round-robin between readers,
// m1 writes pass straight through whenever no read is in flight.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : sram_arbiter_if.slave (m0/m1 requester channels, s_* SRAM side)
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | no read outstanding; writes accepted, reads granted
// BUSY  | read outstanding for owner_q; s_rd_en/s_rd_addr held
module sram_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int NUM_OF_BYTES = DATA_WIDTH / 8
) (
  input logic           clk,
  input logic           rst,
  sram_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic                  s_rd_en_q, s_rd_en_d;
  logic [ADDR_WIDTH-1:0] s_rd_addr_q, s_rd_addr_d;
  logic                  s_cancel_rd_q, s_cancel_rd_d;

  logic                    elig0, elig1;
  logic                    grant0, grant1;
  logic                    owner_cancel;
  logic                    wr_ready;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [NUM_OF_BYTES-1:0] wr_mask;

  assign elig0 = bus.m0_rd_en & ~bus.m0_cancel_rd;
  assign elig1 = bus.m1_rd_en & ~bus.m1_cancel_rd;

  // On a tie the master that did not win last time goes next.
  assign grant1 = elig1 & (~elig0 | ~last_grant_q);
  assign grant0 = elig0 & ~grant1;

  assign owner_cancel = owner_q ? bus.m1_cancel_rd : bus.m0_cancel_rd;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    s_rd_en_d     = s_rd_en_q;
    s_rd_addr_d   = s_rd_addr_q;
    s_cancel_rd_d = 1'b0;
    case (state_q)
      IDLE: begin
        // A write in the same cycle takes the port; reads wait a cycle.
        if (!bus.m1_wr_en && (grant0 || grant1)) begin
          state_d      = BUSY;
          owner_d      = grant1;
          last_grant_d = grant1;
          s_rd_en_d    = 1'b1;
          s_rd_addr_d  = grant1 ? bus.m1_rd_addr : bus.m0_rd_addr;
        end
      end
      BUSY: begin
        // Cancel beats a coincident s_rd_valid: the data is simply dropped.
        if (owner_cancel) begin
          state_d       = IDLE;
          s_rd_en_d     = 1'b0;
          s_cancel_rd_d = 1'b1;
        end else if (bus.s_rd_valid) begin
          state_d   = IDLE;
          s_rd_en_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      s_rd_en_q     <= 1'b0;
      s_rd_addr_q   <= '0;
      s_cancel_rd_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      s_rd_en_q     <= s_rd_en_d;
      s_rd_addr_q   <= s_rd_addr_d;
      s_cancel_rd_q <= s_cancel_rd_d;
    end
  end

  assign bus.s_rd_en     = s_rd_en_q;
  assign bus.s_rd_addr   = s_rd_addr_q;
  assign bus.s_cancel_rd = s_cancel_rd_q;

  // Read completion is returned in the same cycle as s_rd_valid.
  assign bus.m0_rd_valid = (state_q == BUSY) & ~owner_q & bus.s_rd_valid & ~bus.m0_cancel_rd;
  assign bus.m1_rd_valid = (state_q == BUSY) &  owner_q & bus.s_rd_valid & ~bus.m1_cancel_rd;

  assign rd_data         = bus.s_rd_data;
  assign bus.m0_rd_data  = rd_data;
  assign bus.m1_rd_data  = rd_data;

  // Write pass-through; rst gates it because state_q already reads IDLE in reset.
  assign wr_ready        = (state_q == IDLE);
  assign bus.m1_wr_ready = wr_ready;
  assign bus.s_wr_en     = bus.m1_wr_en & wr_ready & ~rst;
  assign bus.s_wr_addr   = bus.m1_wr_addr;
  assign bus.s_wr_data   = bus.m1_wr_data;
  assign wr_mask         = bus.m1_wr_mask;
  assign bus.s_wr_mask   = wr_mask;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_arbiter_if bus ();

  sram_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        mst;
    logic [31:0] data;
  } rd_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } wr_exp_t;

  logic [31:0] q_grant[$];
  rd_exp_t     q_rd[$];
  wr_exp_t     q_wr[$];

  int checks = 0;
  int errors = 0;
  logic prev_rd_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_valid(input logic [31:0] d);
    bus.s_rd_valid = 1'b1;
    bus.s_rd_data  = d;
    step();
    bus.s_rd_valid = 1'b0;
    bus.s_rd_data  = '0;
  endtask

  function automatic rd_exp_t mk_rd(input logic m, input logic [31:0] d);
    rd_exp_t r;
    r.mst  = m;
    r.data = d;
    return r;
  endfunction

  function automatic wr_exp_t mk_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    wr_exp_t w;
    w.addr = a;
    w.data = d;
    w.mask = m;
    return w;
  endfunction

  // Monitor: grants, read returns and writes are popped from the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.s_rd_en && !prev_rd_en) begin
        if (q_grant.size() == 0) chk("grant_unexpected", bus.s_rd_addr, 32'hFFFF_FFFF);
        else chk("grant_addr", bus.s_rd_addr, q_grant.pop_front());
      end
      if (bus.m0_rd_valid && bus.m1_rd_valid) begin
        chk("rd_valid_both", 32'd2, 32'd1);
      end else if (bus.m0_rd_valid || bus.m1_rd_valid) begin
        rd_exp_t e;
        if (q_rd.size() == 0) begin
          chk("rd_unexpected", {31'b0, bus.m1_rd_valid}, 32'hFFFF_FFFF);
        end else begin
          e = q_rd.pop_front();
          chk("rd_master", {31'b0, bus.m1_rd_valid}, {31'b0, e.mst});
          chk("rd_data", bus.m1_rd_valid ? bus.m1_rd_data : bus.m0_rd_data, e.data);
        end
      end
      if (bus.s_wr_en) begin
        wr_exp_t w;
        if (q_wr.size() == 0) begin
          chk("wr_unexpected", bus.s_wr_addr, 32'hFFFF_FFFF);
        end else begin
          w = q_wr.pop_front();
          chk("wr_addr", bus.s_wr_addr, w.addr);
          chk("wr_data", bus.s_wr_data, w.data);
          chk("wr_mask", {28'b0, bus.s_wr_mask}, {28'b0, w.mask});
        end
      end
    end
    prev_rd_en = bus.s_rd_en;
  end

  // The owner must keep rd_en up (or cancel) while its read is outstanding.
  always @(posedge clk) begin
    if (!rst && bus.s_rd_en) begin
      if (dut.owner_q)
        assert (bus.m1_rd_en || bus.m1_cancel_rd)
        else begin errors++; $display("FAIL protocol_m1 rd_en=0 required=1 t=%0t", $time); end
      else
        assert (bus.m0_rd_en || bus.m0_cancel_rd)
        else begin errors++; $display("FAIL protocol_m0 rd_en=0 required=1 t=%0t", $time); end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog elapsed=%0t limit=200000", $time);
    $fatal(1);
  end

  initial begin
    bus.m0_rd_en = 0; bus.m0_rd_addr = '0; bus.m0_cancel_rd = 0;
    bus.m1_rd_en = 0; bus.m1_rd_addr = '0; bus.m1_cancel_rd = 0;
    bus.m1_wr_en = 1; bus.m1_wr_addr = 32'h44; bus.m1_wr_data = 32'h1; bus.m1_wr_mask = 4'hF;
    bus.s_rd_valid = 0; bus.s_rd_data = '0;

    // Reset state, write blocked while in reset
    @(negedge clk);
    chk("rst_s_wr_en", {31'b0, bus.s_wr_en}, 32'd0);
    chk("rst_s_rd_en", {31'b0, bus.s_rd_en}, 32'd0);
    chk("rst_s_rd_addr", bus.s_rd_addr, 32'd0);
    chk("rst_s_cancel", {31'b0, bus.s_cancel_rd}, 32'd0);
    chk("rst_m0_valid", {31'b0, bus.m0_rd_valid}, 32'd0);
    chk("rst_m1_valid", {31'b0, bus.m1_rd_valid}, 32'd0);
    step();
    bus.m1_wr_en = 0;
    rst = 0;

    // Single read, slave latency 3 after s_rd_en
    bus.m0_rd_en = 1; bus.m0_rd_addr = 32'h1C00_0000;
    q_grant.push_back(32'h1C00_0000);
    q_rd.push_back(mk_rd(1'b0, 32'hDEAD_BEEF));
    @(negedge clk);
    chk("t1_c0_s_rd_en", {31'b0, bus.s_rd_en}, 32'd0);
    step();
    @(negedge clk);
    chk("t1_c1_s_rd_en", {31'b0, bus.s_rd_en}, 32'd1);
    chk("t1_busy_wr_ready", {31'b0, bus.m1_wr_ready}, 32'd0);
    step(); step(); step();
    bus.s_rd_valid = 1; bus.s_rd_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t1_m0_valid", {31'b0, bus.m0_rd_valid}, 32'd1);
    chk("t1_m1_valid", {31'b0, bus.m1_rd_valid}, 32'd0);
    step();
    bus.s_rd_valid = 0; bus.s_rd_data = '0; bus.m0_rd_en = 0;
    @(negedge clk);
    chk("t1_done_s_rd_en", {31'b0, bus.s_rd_en}, 32'd0);
    step();

    // Round-robin from reset
    rst = 1; step(); rst = 0;
    bus.m0_rd_en = 1; bus.m0_rd_addr = 32'h100;
    bus.m1_rd_en = 1; bus.m1_rd_addr = 32'h200;
    q_grant.push_back(32'h100); q_grant.push_back(32'h200); q_grant.push_back(32'h100);
    q_rd.push_back(mk_rd(1'b0, 32'hA0A0_0001));
    q_rd.push_back(mk_rd(1'b1, 32'hB0B0_0002));
    q_rd.push_back(mk_rd(1'b0, 32'hA0A0_0003));
    step(); step(); pulse_valid(32'hA0A0_0001);
    step(); step(); pulse_valid(32'hB0B0_0002);
    step(); step(); pulse_valid(32'hA0A0_0003);
    bus.m0_rd_en = 0; bus.m1_rd_en = 0;
    step();

    // Write priority, then write stall while BUSY
    bus.m1_wr_en = 1; bus.m1_wr_addr = 32'h80; bus.m1_wr_data = 32'h1234_5678; bus.m1_wr_mask = 4'hF;
    bus.m0_rd_en = 1; bus.m0_rd_addr = 32'h300;
    q_wr.push_back(mk_wr(32'h80, 32'h1234_5678, 4'hF));
    q_grant.push_back(32'h300);
    q_rd.push_back(mk_rd(1'b0, 32'h3333_3333));
    @(negedge clk);
    chk("t3_wr_ready", {31'b0, bus.m1_wr_ready}, 32'd1);
    chk("t3_s_wr_en", {31'b0, bus.s_wr_en}, 32'd1);
    step();
    bus.m1_wr_en = 0;
    @(negedge clk);
    chk("t3_no_grant", {31'b0, bus.s_rd_en}, 32'd0);
    step();
    bus.m1_wr_en = 1; bus.m1_wr_addr = 32'h90; bus.m1_wr_data = 32'hCAFE_F00D; bus.m1_wr_mask = 4'h3;
    q_wr.push_back(mk_wr(32'h90, 32'hCAFE_F00D, 4'h3));
    @(negedge clk);
    chk("t3_granted", {31'b0, bus.s_rd_en}, 32'd1);
    chk("t4_stall_ready_a", {31'b0, bus.m1_wr_ready}, 32'd0);
    chk("t4_stall_wr_en_a", {31'b0, bus.s_wr_en}, 32'd0);
    step();
    @(negedge clk);
    chk("t4_stall_wr_en_b", {31'b0, bus.s_wr_en}, 32'd0);
    step();
    bus.s_rd_valid = 1; bus.s_rd_data = 32'h3333_3333;
    @(negedge clk);
    chk("t4_stall_ready_c", {31'b0, bus.m1_wr_ready}, 32'd0);
    chk("t4_stall_wr_en_c", {31'b0, bus.s_wr_en}, 32'd0);
    step();
    bus.s_rd_valid = 0; bus.s_rd_data = '0; bus.m0_rd_en = 0;
    @(negedge clk);
    chk("t4_release_ready", {31'b0, bus.m1_wr_ready}, 32'd1);
    chk("t4_release_wr_en", {31'b0, bus.s_wr_en}, 32'd1);
    step();
    bus.m1_wr_en = 0;
    step();

    // Cancel race: owner m1 cancels in the s_rd_valid cycle, m0 pending
    bus.m1_rd_en = 1; bus.m1_rd_addr = 32'h400;
    q_grant.push_back(32'h400);
    step();
    bus.m0_rd_en = 1; bus.m0_rd_addr = 32'h500;
    q_grant.push_back(32'h500);
    q_rd.push_back(mk_rd(1'b0, 32'h5555_5555));
    step();
    bus.m1_cancel_rd = 1; bus.s_rd_valid = 1; bus.s_rd_data = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("t5_m1_valid", {31'b0, bus.m1_rd_valid}, 32'd0);
    chk("t5_m0_valid", {31'b0, bus.m0_rd_valid}, 32'd0);
    step();
    bus.m1_cancel_rd = 0; bus.m1_rd_en = 0; bus.s_rd_valid = 0; bus.s_rd_data = '0;
    @(negedge clk);
    chk("t5_s_cancel", {31'b0, bus.s_cancel_rd}, 32'd1);
    chk("t5_s_rd_en", {31'b0, bus.s_rd_en}, 32'd0);
    chk("t5_idle_ready", {31'b0, bus.m1_wr_ready}, 32'd1);
    step();
    @(negedge clk);
    chk("t5_cancel_one_cycle", {31'b0, bus.s_cancel_rd}, 32'd0);
    chk("t5_m0_granted", {31'b0, bus.s_rd_en}, 32'd1);
    step();
    pulse_valid(32'h5555_5555);
    bus.m0_rd_en = 0;

    // Ignored inputs in IDLE
    bus.s_rd_valid = 1; bus.s_rd_data = 32'h7777_0000;
    bus.m0_cancel_rd = 1; bus.m1_cancel_rd = 1;
    @(negedge clk);
    chk("ign_m0_valid", {31'b0, bus.m0_rd_valid}, 32'd0);
    chk("ign_m1_valid", {31'b0, bus.m1_rd_valid}, 32'd0);
    step();
    bus.s_rd_valid = 0; bus.s_rd_data = '0; bus.m0_cancel_rd = 0; bus.m1_cancel_rd = 0;
    @(negedge clk);
    chk("ign_s_cancel", {31'b0, bus.s_cancel_rd}, 32'd0);
    chk("ign_s_rd_en", {31'b0, bus.s_rd_en}, 32'd0);
    step();

    // Async reset mid-read, then tie goes to m0
    bus.m0_rd_en = 1; bus.m0_rd_addr = 32'h600;
    q_grant.push_back(32'h600);
    step();
    bus.m1_rd_en = 1; bus.m1_rd_addr = 32'h700;
    step();
    #2 rst = 1;
    #1;
    chk("t6_rst_s_rd_en", {31'b0, bus.s_rd_en}, 32'd0);
    chk("t6_rst_s_cancel", {31'b0, bus.s_cancel_rd}, 32'd0);
    chk("t6_rst_idle", {31'b0, bus.m1_wr_ready}, 32'd1);
    step();
    rst = 0;
    q_grant.push_back(32'h600);
    q_rd.push_back(mk_rd(1'b0, 32'h6666_6666));
    q_grant.push_back(32'h700);
    q_rd.push_back(mk_rd(1'b1, 32'h7777_7777));
    step(); step();
    pulse_valid(32'h6666_6666);
    bus.m0_rd_en = 0;
    step(); step();
    pulse_valid(32'h7777_7777);
    bus.m1_rd_en = 0;
    step(); step();

    chk("grant_queue_empty", q_grant.size(), 32'd0);
    chk("rd_queue_empty", q_rd.size(), 32'd0);
    chk("wr_queue_empty", q_wr.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
